// File: rtl/pll_lock_sequencer.sv
// PLL supervisor on the 27 MHz board clock: pulses the rPLL RESET pin, qualifies LOCK,
// and holds the PLL-domain system reset until lock has been continuously stable.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 27000,
    parameter int STABLE_CYCLES = 2700,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 16
) (
    input  logic       clkin_27mhz,
    input  logic       resetn,
    input  logic       lock,
    input  logic       relock_req,
    output logic       pll_reset,
    output logic       sys_resetn,
    output logic       locked,
    output logic       fail,
    output logic [1:0] state,
    output logic [7:0] retry_cnt,
    output logic [7:0] lost_cnt
);

    typedef enum logic [1:0] {
        PLL_RST     = 2'b00,
        WAIT_LOCK   = 2'b01,
        STABLE_WAIT = 2'b10,
        RUN         = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [7:0]       MAX_R       = 8'(MAX_RETRIES);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_lock_meta;
    logic             r_lock_s;
    logic             r_pll_reset;
    logic             r_sys_resetn;
    logic             r_locked;
    logic             r_fail;
    logic [7:0]       r_retry_cnt;
    logic [7:0]       r_lost_cnt;
    logic             w_retry_inc;
    logic             w_lost_inc;
    logic [7:0]       w_retry_plus;

    assign pll_reset  = r_pll_reset;
    assign sys_resetn = r_sys_resetn;
    assign locked     = r_locked;
    assign fail       = r_fail;
    assign state      = r_state;
    assign retry_cnt  = r_retry_cnt;
    assign lost_cnt   = r_lost_cnt;

    assign w_retry_plus = (r_retry_cnt == 8'hFF) ? r_retry_cnt : r_retry_cnt + 8'd1;

    always_comb begin
        w_next      = r_state;
        w_cnt_next  = r_cnt;
        w_retry_inc = 1'b0;
        w_lost_inc  = 1'b0;
        if (relock_req) begin
            w_next     = PLL_RST;
            w_cnt_next = '0;
        end else begin
            case (r_state)
                PLL_RST: begin
                    if (r_cnt == RST_LAST) begin
                        w_next     = WAIT_LOCK;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    // Lock beats a coincident timeout.
                    if (r_lock_s) begin
                        w_next     = STABLE_WAIT;
                        w_cnt_next = '0;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_next      = PLL_RST;
                        w_cnt_next  = '0;
                        w_retry_inc = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                STABLE_WAIT: begin
                    if (!r_lock_s) begin
                        w_next     = WAIT_LOCK;
                        w_cnt_next = '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_next     = RUN;
                        w_cnt_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    w_cnt_next = '0;
                    if (!r_lock_s) begin
                        w_next     = PLL_RST;
                        w_lost_inc = 1'b1;
                    end
                end
                default: begin
                    w_next     = PLL_RST;
                    w_cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clkin_27mhz or negedge resetn) begin
        if (!resetn) begin
            r_state      <= PLL_RST;
            r_cnt        <= '0;
            r_lock_meta  <= 1'b0;
            r_lock_s     <= 1'b0;
            r_pll_reset  <= 1'b1;
            r_sys_resetn <= 1'b0;
            r_locked     <= 1'b0;
            r_fail       <= 1'b0;
            r_retry_cnt  <= 8'd0;
            r_lost_cnt   <= 8'd0;
        end else begin
            r_lock_meta  <= lock;
            r_lock_s     <= r_lock_meta;
            r_state      <= w_next;
            r_cnt        <= w_cnt_next;
            // Outputs decode the next state so they move on the same edge as the state.
            r_pll_reset  <= (w_next == PLL_RST);
            r_sys_resetn <= (w_next == RUN);
            r_locked     <= (w_next == RUN);
            if (w_next == RUN && r_state != RUN) begin
                r_retry_cnt <= 8'd0;
            end else if (w_retry_inc) begin
                r_retry_cnt <= w_retry_plus;
            end
            if (w_retry_inc && w_retry_plus == MAX_R) begin
                r_fail <= 1'b1;
            end
            if (w_lost_inc && r_lost_cnt != 8'hFF) begin
                r_lost_cnt <= r_lost_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer: every state transition is predicted (state, outputs,
// counters, cycle number) into a queue that a negedge monitor pops and compares.
module tb_pll_lock_sequencer;

    localparam int EXP_W = 2 + 4 + 16 + 32;

    logic       clk;
    logic       resetn;
    logic       lock;
    logic       relock_req;
    logic       pll_reset;
    logic       sys_resetn;
    logic       locked;
    logic       fail;
    logic [1:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] lost_cnt;

    logic [31:0]      cyc;
    logic [EXP_W-1:0] exp_q[$];
    logic [1:0]       prev_st;
    int               n_checks;
    int               n_err;

    pll_lock_sequencer #(
        .RST_CYCLES(4),
        .LOCK_TIMEOUT(20),
        .STABLE_CYCLES(8),
        .MAX_RETRIES(2),
        .CNT_W(16)
    ) dut (
        .clkin_27mhz(clk),
        .resetn(resetn),
        .lock(lock),
        .relock_req(relock_req),
        .pll_reset(pll_reset),
        .sys_resetn(sys_resetn),
        .locked(locked),
        .fail(fail),
        .state(state),
        .retry_cnt(retry_cnt),
        .lost_cnt(lost_cnt)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected transitions pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic string fmt(input logic [EXP_W-1:0] r);
        return $sformatf("st=%0d pll=%0b sysn=%0b lck=%0b fail=%0b retry=%0d lost=%0d cyc=%0d",
                         r[53:52], r[51], r[50], r[49], r[48], r[47:40], r[39:32], r[31:0]);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] st, input logic pll, input logic sysn, input logic lck,
                        input logic fl, input logic [7:0] rt, input logic [7:0] lt,
                        input logic [31:0] at);
        exp_q.push_back({st, pll, sysn, lck, fl, rt, lt, at});
    endtask

    task automatic wait_until(input logic [31:0] target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
        chk({tag, "_sys_resetn"}, 32'(sys_resetn), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_fail"}, 32'(fail), 32'd0);
        chk({tag, "_retry_cnt"}, 32'(retry_cnt), 32'd0);
        chk({tag, "_lost_cnt"}, 32'(lost_cnt), 32'd0);
    endtask

    // Release reset #1 after a negedge; PLL_RST lasts 4 edges, then WAIT_LOCK.
    task automatic release_reset(output logic [31:0] c);
        c = cyc;
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, c + 32'd4);
        #1 resetn = 1'b1;
    endtask

    task automatic do_reset(input string tag, output logic [31:0] c);
        @(negedge clk);
        lock       = 1'b0;
        relock_req = 1'b0;
        resetn     = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
        chk_reset_vals(tag);
        release_reset(c);
    endtask

    // Raise lock at this negedge: STABLE_WAIT 3 edges later, RUN 8 edges after that.
    task automatic lock_on(input logic fl, input logic [7:0] rt_stable, input logic [7:0] lt,
                           output logic [31:0] k);
        k = cyc;
        push(2'b10, 1'b0, 1'b0, 1'b0, fl, rt_stable, lt, k + 32'd3);
        push(2'b11, 1'b0, 1'b1, 1'b1, fl, 8'd0, lt, k + 32'd11);
        lock = 1'b1;
    endtask

    task automatic pulse_relock;
        relock_req = 1'b1;
        @(negedge clk);
        relock_req = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] obs;
        logic [EXP_W-1:0] e;
        if (!resetn) begin
            prev_st = state;
        end else if (state !== prev_st) begin
            obs = {state, pll_reset, sys_resetn, locked, fail, retry_cnt, lost_cnt, cyc};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_transition: got %s, expected no transition", fmt(obs));
            end else begin
                e = exp_q.pop_front();
                if (obs !== e) begin
                    n_err++;
                    $display("FAIL transition: got %s, expected %s", fmt(obs), fmt(e));
                end
            end
            prev_st = state;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] c;
        logic [31:0] k;
        n_checks   = 0;
        n_err      = 0;
        resetn     = 1'b0;
        lock       = 1'b0;
        relock_req = 1'b0;
        prev_st    = 2'b00;

        // 1: clean bring-up, lock 3 cycles after pll_reset falls
        do_reset("s1", c);
        wait_until(c + 32'd6);
        lock_on(1'b0, 8'd0, 8'd0, k);
        wait_until(k + 32'd13);
        chk("s1_run_state", 32'(state), 32'd3);
        chk("s1_locked", 32'(locked), 32'd1);

        // 3: one-cycle lock glitch seen while the stable counter is 5
        do_reset("s3", c);
        wait_until(c + 32'd5);
        k = cyc;
        push(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, k + 32'd3);
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, k + 32'd9);
        push(2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, k + 32'd10);
        push(2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0, 8'd0, k + 32'd18);
        lock = 1'b1;
        wait_until(k + 32'd6);
        lock = 1'b0;
        @(negedge clk);
        lock = 1'b1;
        wait_until(k + 32'd20);

        // 2: no lock -> retries every 24 cycles, fail at retry 2, then lock arrives
        do_reset("s2", c);
        push(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, c + 32'd24);
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, c + 32'd28);
        push(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2, 8'd0, c + 32'd48);
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd0, c + 32'd52);
        push(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd3, 8'd0, c + 32'd72);
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'd3, 8'd0, c + 32'd76);
        wait_until(c + 32'd78);
        lock_on(1'b1, 8'd3, 8'd0, k);
        wait_until(k + 32'd13);
        chk("s2_retry_cleared", 32'(retry_cnt), 32'd0);
        chk("s2_fail_sticky", 32'(fail), 32'd1);

        // 4: lock loss in RUN
        k = cyc;
        push(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, k + 32'd3);
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, k + 32'd7);
        lock = 1'b0;
        wait_until(k + 32'd8);
        lock_on(1'b1, 8'd0, 8'd1, k);
        wait_until(k + 32'd13);

        // 5: relock in RUN, then again in PLL_RST at counter 2
        k = cyc;
        push(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, k + 32'd1);
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, k + 32'd8);
        push(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, k + 32'd9);
        push(2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0, 8'd1, k + 32'd17);
        pulse_relock();
        wait_until(k + 32'd3);
        pulse_relock();
        wait_until(k + 32'd19);
        chk("s5_lost_unchanged", 32'(lost_cnt), 32'd1);

        // 6: asynchronous reset while in STABLE_WAIT (reached via relock)
        k = cyc;
        push(2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, k + 32'd1);
        push(2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, k + 32'd5);
        push(2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 8'd1, k + 32'd6);
        pulse_relock();
        wait_until(k + 32'd8);
        chk("s6_in_stable", 32'(state), 32'd2);
        #2 resetn = 1'b0;
        #1 chk_reset_vals("s6_async");
        lock = 1'b0;
        @(negedge clk);
        chk("s6_queue_drained", 32'(exp_q.size()), 32'd0);
        release_reset(c);
        wait_until(c + 32'd6);
        lock_on(1'b0, 8'd0, 8'd0, k);
        wait_until(k + 32'd13);
        chk("s6_rerun_locked", 32'(locked), 32'd1);

        repeat (3) @(negedge clk);
        chk("final_queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Supervises the core rPLL: drives the PLL RESET pin, qualifies LOCK, and generates the active-low system reset for the PLL-clocked domain (picorv32 core and peripherals). Runs entirely on the 27 MHz board clock, which is valid before the PLL output is. Retries the PLL on lock timeout and recovers automatically on loss of lock or on a software relock request.

Parameters:
RST_CYCLES, 16, cycles pll_reset is held high per PLL reset pulse (>=1)
LOCK_TIMEOUT, 27000, cycles to wait for lock after a PLL reset before retrying (1 ms at 27 MHz)
STABLE_CYCLES, 2700, consecutive cycles of synchronized lock required before releasing system reset (100 us)
MAX_RETRIES, 4, consecutive timeouts after which fail is raised (1..255)
CNT_W, 16, width of the shared cycle counter; every cycle parameter must be < 2**CNT_W

Ports:
clkin_27mhz  in  1  board clock; the only clock
resetn  in  1  asynchronous active-low reset
lock  in  1  rPLL LOCK, asynchronous to clkin_27mhz
relock_req  in  1  single-cycle pulse, synchronous; forces a new PLL reset cycle
pll_reset  out  1  to rPLL RESET, active high
sys_resetn  out  1  active-low reset for PLL domain; consumer synchronizes deassertion
locked  out  1  high only in RUN
fail  out  1  sticky; MAX_RETRIES consecutive lock timeouts occurred
state  out  2  current FSM state (00 PLL_RST, 01 WAIT_LOCK, 10 STABLE_WAIT, 11 RUN)
retry_cnt  out  8  consecutive lock timeouts, saturating at 255
lost_cnt  out  8  lock losses while in RUN, saturating at 255

Behaviour:
- Reset (resetn=0, asynchronous): state=PLL_RST, counter=0, pll_reset=1, sys_resetn=0, locked=0, fail=0, retry_cnt=0, lost_cnt=0, sync flops=0.
- Lock synchronizer: 2 flops; lock_s is lock delayed 2 edges. The FSM uses only lock_s.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state.
- PLL_RST: pll_reset=1, sys_resetn=0. Counter increments; when counter==RST_CYCLES-1, go to WAIT_LOCK and clear the counter. pll_reset is therefore high for exactly RST_CYCLES cycles.
- WAIT_LOCK: pll_reset=0. If lock_s=1, go to STABLE_WAIT with counter=0.
  - Else if counter==LOCK_TIMEOUT-1, go to PLL_RST and increment retry_cnt (saturating).
  - fail is set when the incremented retry_cnt equals MAX_RETRIES.
- STABLE_WAIT: counter increments while lock_s=1.
  - When counter==STABLE_CYCLES-1, go to RUN. Latency from the first edge sampling lock=1 to sys_resetn=1 is STABLE_CYCLES+2 edges.
  - If lock_s=0, go to WAIT_LOCK with counter=0 (no PLL reset; full timeout restarts).
- RUN: sys_resetn=1, locked=1, retry_cnt cleared on entry. fail stays set.
  - If lock_s=0, go to PLL_RST on the next edge and increment lost_cnt (saturating).
  - sys_resetn and locked fall on that same edge.
- relock_req=1 in any state: go to PLL_RST with counter=0; highest priority. It does not change retry_cnt or lost_cnt.
- relock_req during PLL_RST: restarts the RST_CYCLES count.
- Simultaneous timeout and lock_s=1 in WAIT_LOCK: lock wins, go to STABLE_WAIT.
- Counter saturation is never reached; it is always cleared on a state change.
- fail is cleared only by resetn. The sequencer keeps retrying indefinitely after fail.
- resetn asserted mid-operation: immediate return to reset values, including pll_reset=1 asynchronously.

Test Plan:
All scenarios use RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Release resetn, lock rises 3 cycles after pll_reset falls -> pll_reset high exactly 4 cycles; sys_resetn rises 10 edges after lock is first sampled; state=11; locked=1.
2. Lock never asserts -> pll_reset pulses (4 cycles high, 20 low) repeat; retry_cnt counts 1,2,3...; fail rises with retry_cnt=2 and stays high; after lock then arrives, RUN is reached, retry_cnt=0, fail still 1.
3. Lock glitches low for 1 cycle during STABLE_WAIT counter=5 -> state returns to 01 with no pll_reset pulse; sys_resetn rises 8 cycles after lock_s is high again, plus 1 edge.
4. In RUN, drop lock -> 2 edges later sys_resetn=0, state=00, pll_reset=1, lost_cnt=1; lock returns -> RUN reached again.
5. relock_req pulse in RUN and in PLL_RST at counter=2 -> immediate PLL_RST entry; pll_reset held 4 cycles from the last request; counters unchanged.
6. Assert resetn low in STABLE_WAIT -> pll_reset=1 and sys_resetn=0 asynchronously, all counters 0; normal sequence from scenario 1 on release.
